// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the I/D requester, memory-port and status signals of mem_port_arbiter.
// Latency: none (wires only).
// Backpressure: carries the req/done handshakes and mem_ready, so stalls pass straight through.
//
// Modports:
//   slave  - the arbiter: samples requests and memory responses, drives done/rdata/stall/mux/err.
//   master - the surrounding pipeline and memory: drive requests and responses, observe results.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // instruction fetch side
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_done;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_stall;
    // data load/store side
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_done;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_stall;
    // shared memory port
    logic                  mem_sel;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    // watchdog status
    logic                  err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
               mem_sel, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_done, i_rdata, i_stall, d_done, d_rdata, d_stall,
               mem_sel, mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch (I) and data access (D).
// Latency: request seen in IDLE at N -> mem_req at N+1; mem_ready at M -> done at M+1; next grant at M+2.
// Backpressure: requesters hold req and operands until their done pulse; memory stalls by holding mem_ready low.
//
// Ports: clk, reset (synchronous, active-high), bus (mem_port_arbiter_if.slave):
//   I side : i_req, i_addr -> i_done, i_rdata, i_stall
//   D side : d_req, d_we, d_addr, d_wdata -> d_done, d_rdata, d_stall
//   memory : mem_sel, mem_req, mem_we, mem_addr, mem_wdata <- mem_ready, mem_rdata; err
// Build option: define ARB_TIMEOUT_EN to enable a TIMEOUT-cycle BUSY watchdog (err is tied 0 otherwise).
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam int            SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    // Both limits size counters and comparisons; a zero value would make the block meaningless.
    if (MAX_D_STREAK < 1 || TIMEOUT < 1) begin : g_param_check
        $error("mem_port_arbiter: MAX_D_STREAK and TIMEOUT must both be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic                  sel_q,     sel_d;
    logic [SW-1:0]         streak_q,  streak_d;
    logic                  i_done_q,  i_done_d;
    logic                  d_done_q,  d_done_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  d_wins;

`ifdef ARB_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        streak_d  = streak_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        d_wins    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // D is preferred, but once it has taken MAX_D_STREAK grants in a row
                // while I was waiting, I is forced through.
                d_wins = bus.d_req & (~bus.i_req | (streak_q < STREAK_MAX));

                // The streak only measures D grants that made I wait.
                if (!bus.i_req) begin
                    streak_d = '0;
                end

                if (d_wins) begin
                    sel_d   = 1'b1;
                    state_d = BUSY;
                    if (bus.i_req && (streak_q < STREAK_MAX)) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (bus.i_req) begin
                    sel_d    = 1'b0;
                    state_d  = BUSY;
                    streak_d = '0;
                end
`ifdef ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end

            BUSY: begin
                if (bus.mem_ready) begin
                    state_d = RESP;
                    if (sel_q) begin
                        d_rdata_d = bus.mem_rdata;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = bus.mem_rdata;
                        i_done_d  = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                // mem_ready takes priority over the watchdog in the final cycle.
                else if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (sel_q) begin
                        d_rdata_d = '1;
                        d_done_d  = 1'b1;
                    end else begin
                        i_rdata_d = '1;
                        i_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            // The done pulse is visible here; no arbitration, so the finishing
            // requester can already present its next request without a double grant.
            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            streak_q  <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            streak_q  <= streak_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Memory-port muxes follow the registered select; operands come straight
    // from the requesters, which keep them stable until done.
    assign bus.mem_req   = (state_q == BUSY);
    assign bus.mem_sel   = sel_q;
    assign bus.mem_we    = sel_q & bus.d_we;
    assign bus.mem_addr  = sel_q ? bus.d_addr  : bus.i_addr;
    assign bus.mem_wdata = sel_q ? bus.d_wdata : '0;

    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_stall   = bus.i_req & ~i_done_q;
    assign bus.d_stall   = bus.d_req & ~d_done_q;

`ifdef ARB_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: the bench plays both requesters and the memory, holding requests until done.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_D_STREAK(MAXS),
        .TIMEOUT     (TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic idle_inputs();
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.mem_ready = 1'b1;   // must be ignored while in reset
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.mem_sel, bus.i_done, bus.d_done, bus.err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req/sel/idone/ddone/err=%b want 00000",
                     {bus.mem_req, bus.mem_sel, bus.i_done, bus.d_done, bus.err});
        end
        n_cmp++;
        if (bus.i_rdata !== '0 || bus.d_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: i=%h d=%h want 0/0", bus.i_rdata, bus.d_rdata);
        end
        bus.mem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_i_read();
        bit d_seen = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        @(negedge clk);                                   // first BUSY cycle
        d_seen |= bus.d_done;
        n_cmp++;
        if ({bus.mem_req, bus.mem_sel, bus.mem_we} !== 3'b100 || bus.mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL i_read_grant: req/sel/we=%b addr=%h want 100 addr=00000100",
                     {bus.mem_req, bus.mem_sel, bus.mem_we}, bus.mem_addr);
        end
        @(negedge clk);                                   // second BUSY cycle, no ready yet
        d_seen |= bus.d_done;
        n_cmp++;
        if (bus.mem_req !== 1'b1 || bus.i_done !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_wait: mem_req=%b i_done=%b want 1/0", bus.mem_req, bus.i_done);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;                             // ready two cycles after mem_req
        bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        d_seen |= bus.d_done;
        n_cmp++;
        if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_done: i_done=%b i_rdata=%h mem_req=%b want 1/deadbeef/0",
                     bus.i_done, bus.i_rdata, bus.mem_req);
        end
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        d_seen |= bus.d_done;
        n_cmp++;
        if (bus.i_done !== 1'b0 || bus.i_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_pulse: i_done=%b i_stall=%b want 0/0", bus.i_done, bus.i_stall);
        end
        n_cmp++;
        if (d_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL i_read_no_d: d_done seen=%b want 0", d_seen);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h300;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 32'h200;
        bus.d_wdata   = 32'h55;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.mem_sel, bus.mem_we} !== 3'b111 || bus.mem_wdata !== 32'h55 ||
            bus.mem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL simul_d_first: req/sel/we=%b wdata=%h addr=%h want 111/55/200",
                     {bus.mem_req, bus.mem_sel, bus.mem_we}, bus.mem_wdata, bus.mem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.d_done !== 1'b1 || bus.i_done !== 1'b0 || bus.i_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_d_done: d_done=%b i_done=%b i_stall=%b want 1/0/1",
                     bus.d_done, bus.i_done, bus.i_stall);
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_idle_gap: mem_req=%b want 0", bus.mem_req);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.mem_sel, bus.mem_we} !== 3'b100 || bus.mem_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL simul_i_next: req/sel/we=%b addr=%h want 100/300",
                     {bus.mem_req, bus.mem_sel, bus.mem_we}, bus.mem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.i_done !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_i_done: i_done=%b want 1", bus.i_done);
        end
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_starvation();
        bit got[10];
        int g    = 0;
        bit prev = 1'b0;
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h1000;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'h2000;
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 200 && g < 10; c++) begin
            @(negedge clk);
            if (bus.mem_req && !prev) begin
                got[g] = bus.mem_sel;
                g++;
            end
            prev = bus.mem_req;
            if (bus.d_done) bus.d_addr = bus.d_addr + 32'd4;
            if (bus.i_done) bus.i_addr = bus.i_addr + 32'd4;
        end
        n_cmp++;
        if (g != 10) begin
            n_fail++;
            $display("FAIL starve_budget: grants=%0d want 10", g);
        end
        // MAXS data grants, then one forced fetch, repeating.
        for (int k = 0; k < g; k++) begin
            n_cmp++;
            if (got[k] !== ((k % (MAXS + 1)) != MAXS)) begin
                n_fail++;
                $display("FAIL starve_order[%0d]: sel=%b want %b", k, got[k],
                         ((k % (MAXS + 1)) != MAXS));
            end
        end
        bus.i_req     = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          grants  = 0;
        int          low_run = 0;
        bit          prev    = 1'b0;
        logic [31:0] exp_addr = 32'h400;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = exp_addr;
        bus.d_wdata   = 32'h1;
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 40 && grants < 4; c++) begin
            @(negedge clk);
            if (bus.mem_req && !prev) begin
                if (grants > 0) begin
                    n_cmp++;
                    if (low_run != 2) begin
                        n_fail++;
                        $display("FAIL b2b_gap[%0d]: low cycles=%0d want 2", grants, low_run);
                    end
                end
                n_cmp++;
                if (bus.mem_addr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL b2b_addr[%0d]: addr=%h want %h", grants, bus.mem_addr, exp_addr);
                end
                grants++;
            end
            low_run = bus.mem_req ? 0 : low_run + 1;
            prev    = bus.mem_req;
            if (bus.d_done) begin          // new request presented in the done cycle
                exp_addr    = exp_addr + 32'd4;
                bus.d_addr  = exp_addr;
                bus.d_wdata = bus.d_wdata + 32'd1;
            end
        end
        n_cmp++;
        if (grants != 4) begin
            n_fail++;
            $display("FAIL b2b_budget: grants=%0d want 4", grants);
        end
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h500;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_grant: mem_req=%b want 1", bus.mem_req);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.mem_req !== 1'b0 || bus.i_done !== 1'b0 || bus.i_rdata !== '0) begin
            n_fail++;
            $display("FAIL rstmid_abort: mem_req=%b i_done=%b i_rdata=%h want 0/0/0",
                     bus.mem_req, bus.i_done, bus.i_rdata);
        end
        reset         = 1'b0;
        bus.i_req     = 1'b0;
        bus.mem_ready = 1'b1;          // late response from the aborted access
        bus.mem_rdata = 32'hBAD0BAD0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_req || bus.i_done || bus.d_done || bus.i_rdata !== '0) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ignore: stray activity=%b want 0", bad);
        end
        bus.mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bus.i_req     = 1'b1;
        bus.i_addr    = 32'h600;
        bus.mem_ready = 1'b0;
`ifdef ARB_TIMEOUT_EN
        begin
            int busy = 0;
            bit seen = 1'b0;
            bit early_err = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                @(negedge clk);
                if (bus.mem_req) busy++;
                if (bus.i_done) begin
                    seen = 1'b1;
                    n_cmp++;
                    if (bus.err !== 1'b1 || bus.i_rdata !== 32'hFFFFFFFF || busy != TMO) begin
                        n_fail++;
                        $display("FAIL timeout_fire: err=%b i_rdata=%h busy=%0d want 1/ffffffff/%0d",
                                 bus.err, bus.i_rdata, busy, TMO);
                    end
                    bus.i_req = 1'b0;
                end else if (bus.err) begin
                    early_err = 1'b1;
                end
            end
            n_cmp++;
            if (!seen || early_err) begin
                n_fail++;
                $display("FAIL timeout_seen: done seen=%b early err=%b want 1/0", seen, early_err);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.err !== 1'b0 || bus.i_done !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_pulse: err=%b i_done=%b want 0/0", bus.err, bus.i_done);
            end
        end
`else
        begin
            bit bad = 1'b0;
            @(negedge clk);
            repeat (30) begin
                @(negedge clk);
                if (!bus.mem_req || bus.err || bus.i_done) bad = 1'b1;
            end
            n_cmp++;
            if (bad !== 1'b0) begin
                n_fail++;
                $display("FAIL no_timeout_stuck: left BUSY or err/done seen=%b want 0", bad);
            end
        end
`endif
        bus.i_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Randomized traffic against a transaction-level model: who owns the port,
    // which response is pending, and how many D grants I has been made to wait.
    task automatic test_random();
        bit          i_act = 1'b0, d_act = 1'b0;
        int          own   = 0;             // 0 none, 1 I transaction open, 2 D transaction open
        bit          resp  = 1'b0;
        bit          e_sel = 1'b0, e_id = 1'b0, e_dd = 1'b0;
        logic [31:0] e_ir  = '0, e_dr = '0;
        int          streak = 0;
        int          wait_cnt = 0;

        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int c = 0; c < 1500; c++) begin
            if (!i_act && $urandom_range(0, 2) == 0) begin
                i_act      = 1'b1;
                bus.i_addr = $urandom;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act       = 1'b1;
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
                bus.d_we    = $urandom_range(0, 1) == 1;
            end
            bus.i_req     = i_act;
            bus.d_req     = d_act;
            bus.mem_ready = ($urandom_range(0, 1) == 1) || (wait_cnt >= 4);
            bus.mem_rdata = $urandom;

            // expected effect of the coming edge
            e_id = 1'b0;
            e_dd = 1'b0;
            if (resp) begin
                resp = 1'b0;
            end else if (own != 0) begin
                if (bus.mem_ready) begin
                    if (own == 1) begin e_ir = bus.mem_rdata; e_id = 1'b1; end
                    else          begin e_dr = bus.mem_rdata; e_dd = 1'b1; end
                    resp = 1'b1;
                    own  = 0;
                end
            end else begin
                if (!i_act) streak = 0;
                if (d_act && (!i_act || streak < MAXS)) begin
                    own   = 2;
                    e_sel = 1'b1;
                    if (i_act && streak < MAXS) streak++;
                end else if (i_act) begin
                    own    = 1;
                    e_sel  = 1'b0;
                    streak = 0;
                end
            end

            @(negedge clk);

            n_cmp++;
            if (bus.mem_req !== (own != 0) || bus.mem_sel !== e_sel) begin
                n_fail++;
                $display("FAIL rnd_port c=%0d: mem_req=%b sel=%b want %b/%b",
                         c, bus.mem_req, bus.mem_sel, (own != 0), e_sel);
            end
            n_cmp++;
            if (bus.i_done !== e_id || bus.d_done !== e_dd) begin
                n_fail++;
                $display("FAIL rnd_done c=%0d: i_done=%b d_done=%b want %b/%b",
                         c, bus.i_done, bus.d_done, e_id, e_dd);
            end
            n_cmp++;
            if (bus.i_rdata !== e_ir || bus.d_rdata !== e_dr) begin
                n_fail++;
                $display("FAIL rnd_rdata c=%0d: i=%h d=%h want %h/%h",
                         c, bus.i_rdata, bus.d_rdata, e_ir, e_dr);
            end
            n_cmp++;
            if (bus.i_stall !== (i_act && !e_id) || bus.d_stall !== (d_act && !e_dd) ||
                bus.err !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_stall c=%0d: i_stall=%b d_stall=%b err=%b want %b/%b/0",
                         c, bus.i_stall, bus.d_stall, bus.err, (i_act && !e_id), (d_act && !e_dd));
            end
            if (own == 1) begin
                n_cmp++;
                if (bus.mem_addr !== bus.i_addr || bus.mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_imux c=%0d: addr=%h we=%b want %h/0",
                             c, bus.mem_addr, bus.mem_we, bus.i_addr);
                end
            end else if (own == 2) begin
                n_cmp++;
                if (bus.mem_addr !== bus.d_addr || bus.mem_we !== bus.d_we ||
                    bus.mem_wdata !== bus.d_wdata) begin
                    n_fail++;
                    $display("FAIL rnd_dmux c=%0d: addr=%h we=%b wdata=%h want %h/%b/%h",
                             c, bus.mem_addr, bus.mem_we, bus.mem_wdata,
                             bus.d_addr, bus.d_we, bus.d_wdata);
                end
            end

            if (e_id) i_act = 1'b0;
            if (e_dd) d_act = 1'b0;
            wait_cnt = (own != 0) ? wait_cnt + 1 : 0;
        end
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_i_read();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
